alu_op_issuer: RTL and testbench

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

---
 rtl/alu_op_issuer.sv | 178 +++++++++++++++++
 tb/tb_alu_op_issuer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues one command at a time to an external 4-bit ALU.
// It holds the operands for a programmable settle time, then captures and masks
// the ALU result and presents it through a valid/ready response port.
//
// Optional build feature: define ALU_ISSUER_OPCNT_EN to add the 16-bit
// op_count output. It counts completed responses and wraps at 16'hFFFF.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for cmd_valid
// WAIT    | operands driven to the ALU, settle counter running down
// RESP    | masked result held on rsp_*, waiting for rsp_ready
module alu_op_issuer #(
  parameter int unsigned SETTLE_CYC = 1   // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [3:0]  cmd_a,
  input  logic [3:0]  cmd_b,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [3:0]  alu_x,
  input  logic [3:0]  alu_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_op,
  output logic [3:0]  rsp_x,
  output logic [3:0]  rsp_y,
`ifdef ALU_ISSUER_OPCNT_EN
  output logic [15:0] op_count,
`endif
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] alu_opcode_q, alu_opcode_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_op_q, rsp_op_d;
  logic [3:0] rsp_x_q, rsp_x_d;
  logic [3:0] rsp_y_q, rsp_y_d;

  // These opcodes produce a flag-style X result: only bit 0 is meaningful.
  function automatic logic [3:0] mask_x(input logic [3:0] op, input logic [3:0] x);
    logic [3:0] r;
    case (op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0110, 4'b0111,
      4'b1000, 4'b1001: r = {3'b000, x[0]};
      default:          r = x;
    endcase
    return r;
  endfunction

  // Y is fully valid for only three opcodes, 1010 yields a single-bit Y,
  // and every other opcode yields a zero Y.
  function automatic logic [3:0] mask_y(input logic [3:0] op, input logic [3:0] y);
    logic [3:0] r;
    case (op)
      4'b1100, 4'b1101, 4'b1110: r = y;
      4'b1010:                   r = {3'b000, y[0]};
      default:                   r = 4'b0000;
    endcase
    return r;
  endfunction

  // Next-state and datapath update for the issue / settle / respond sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_x_d      = rsp_x_q;
    rsp_y_d      = rsp_y_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_opcode_d = cmd_op;
          alu_a_d      = cmd_a;
          alu_b_d      = cmd_b;
          cnt_d        = SETTLE_LD;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The counter is loaded with SETTLE_CYC and needs SETTLE_CYC edges to
        // reach zero. The result is captured on the edge after that, so the
        // response arrives SETTLE_CYC+1 edges after the accept.
        if (cnt_q == 4'd0) begin
          rsp_op_d    = alu_opcode_q;
          rsp_x_d     = mask_x(alu_opcode_q, alu_x);
          rsp_y_d     = mask_y(alu_opcode_q, alu_y);
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // A command presented now is not accepted. It can only be taken from IDLE.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. The synchronous reset overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      alu_opcode_q <= 4'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= 4'd0;
      rsp_x_q      <= 4'd0;
      rsp_y_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_x_q      <= rsp_x_d;
      rsp_y_q      <= rsp_y_d;
    end
  end

`ifdef ALU_ISSUER_OPCNT_EN
  logic [15:0] op_count_q;

  // Count completed response handshakes. The counter wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 16'd0;
    end else if (rsp_valid_q && rsp_ready) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_x      = rsp_x_q;
  assign rsp_y      = rsp_y_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer. Instance 0 uses SETTLE_CYC=1 and
// instance 1 uses SETTLE_CYC=3. The two instances share their command and ALU inputs.
// The op_count checks are built only when ALU_ISSUER_OPCNT_EN is defined.
module tb_alu_op_issuer;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd_valid;
  logic [3:0] cmd_op, cmd_a, cmd_b;
  logic [3:0] alu_x, alu_y;
  logic       rsp_ready;

  logic [1:0] cmd_ready_w, rsp_valid_w, busy_w;
  logic [3:0] alu_opcode_w [2];
  logic [3:0] alu_a_w [2];
  logic [3:0] alu_b_w [2];
  logic [3:0] rsp_op_w [2];
  logic [3:0] rsp_x_w [2];
  logic [3:0] rsp_y_w [2];
`ifdef ALU_ISSUER_OPCNT_EN
  logic [15:0] op_count_w [2];
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_issuer #(.SETTLE_CYC(1)) u_s1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready_w[0]),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode_w[0]), .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]),
    .alu_x(alu_x), .alu_y(alu_y), .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op_w[0]), .rsp_x(rsp_x_w[0]), .rsp_y(rsp_y_w[0]),
`ifdef ALU_ISSUER_OPCNT_EN
    .op_count(op_count_w[0]),
`endif
    .busy(busy_w[0])
  );

  alu_op_issuer #(.SETTLE_CYC(3)) u_s3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready_w[1]),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode_w[1]), .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]),
    .alu_x(alu_x), .alu_y(alu_y), .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op_w[1]), .rsp_x(rsp_x_w[1]), .rsp_y(rsp_y_w[1]),
`ifdef ALU_ISSUER_OPCNT_EN
    .op_count(op_count_w[1]),
`endif
    .busy(busy_w[1])
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks latency on the rising edge of rsp_valid, checks that the
  // response holds steady under back-pressure, and pops the queue on each handshake.
  logic [1:0] prev_valid = 2'b00;
  logic [1:0] prev_hs = 2'b00;
  logic [3:0] held_op [2];
  logic [3:0] held_x [2];
  logic [3:0] held_y [2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      int   sz;
      sz = (k == 0) ? q0.size() : q1.size();
      if (sz > 0) e = (k == 0) ? q0[0] : q1[0];
      if (rsp_valid_w[k] && !prev_valid[k]) begin
        if (sz == 0) chk($sformatf("unexpected_rsp%0d", k), 16'(rsp_valid_w[k]), 16'd0);
        else chk($sformatf("latency%0d", k), 16'(cyc - acc_cyc[k]), 16'(e.lat));
      end
      if (rsp_valid_w[k] && prev_valid[k] && !prev_hs[k]) begin
        chk($sformatf("hold_op%0d", k), 16'(rsp_op_w[k]), 16'(held_op[k]));
        chk($sformatf("hold_x%0d", k), 16'(rsp_x_w[k]), 16'(held_x[k]));
        chk($sformatf("hold_y%0d", k), 16'(rsp_y_w[k]), 16'(held_y[k]));
        chk($sformatf("hold_cmd_ready%0d", k), 16'(cmd_ready_w[k]), 16'd0);
      end
      if (rsp_valid_w[k] && rsp_ready) begin
        if (sz == 0) begin
          chk($sformatf("unexpected_hs%0d", k), 16'(rsp_valid_w[k]), 16'd0);
        end else begin
          chk($sformatf("rsp_op%0d", k), 16'(rsp_op_w[k]), 16'(e.op));
          chk($sformatf("rsp_x%0d", k), 16'(rsp_x_w[k]), 16'(e.x));
          chk($sformatf("rsp_y%0d", k), 16'(rsp_y_w[k]), 16'(e.y));
          if (k == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
      prev_valid[k] = rsp_valid_w[k];
      prev_hs[k]    = rsp_valid_w[k] & rsp_ready;
      held_op[k]    = rsp_op_w[k];
      held_x[k]     = rsp_x_w[k];
      held_y[k]     = rsp_y_w[k];
    end
  end

  // Issue one command to instance k and return just after the accept edge.
  task automatic issue(input int k, input logic [3:0] op, a, b, x, y, ex, ey, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_w[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 16'(cmd_ready_w[k]), 16'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; alu_x = x; alu_y = y;
    cmd_valid[k] = 1'b1;
    e.op = op; e.x = ex; e.y = ey; e.lat = (k == 0) ? 8'd2 : 8'd4;
    if (push) begin
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk); #1;
    acc_cyc[k] = cyc;
    cmd_valid[k] = 1'b0;
    chk("alu_opcode", 16'(alu_opcode_w[k]), 16'(op));
    chk("alu_a", 16'(alu_a_w[k]), 16'(a));
    chk("alu_b", 16'(alu_b_w[k]), 16'(b));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 16'(q0.size() + q1.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  //                  op     a      b      x      y      exp_x  exp_y
  logic [3:0] vec [9][7] = '{
    '{4'hA, 4'h9, 4'h8, 4'h1, 4'h1, 4'h1, 4'h1},
    '{4'h6, 4'h5, 4'h3, 4'hF, 4'hA, 4'h1, 4'h0},
    '{4'hC, 4'h2, 4'h3, 4'h5, 4'h7, 4'h5, 4'h7},
    '{4'h3, 4'h4, 4'h4, 4'hA, 4'hF, 4'hA, 4'h0},
    '{4'h0, 4'h1, 4'h1, 4'hE, 4'hF, 4'h0, 4'h0},
    '{4'hF, 4'h7, 4'h1, 4'h9, 4'h9, 4'h9, 4'h0},
    '{4'hA, 4'h3, 4'h3, 4'h6, 4'hB, 4'h6, 4'h1},
    '{4'hD, 4'h0, 4'h0, 4'h8, 4'h4, 4'h8, 4'h4},
    '{4'h1, 4'h2, 4'h2, 4'h3, 4'h6, 4'h1, 4'h0}
  };

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1; cmd_valid = 2'b00; cmd_op = 4'h0; cmd_a = 4'h0; cmd_b = 4'h0;
    alu_x = 4'h0; alu_y = 4'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 2; k++) begin
      chk("rst_cmd_ready", 16'(cmd_ready_w[k]), 16'd1);
      chk("rst_busy", 16'(busy_w[k]), 16'd0);
      chk("rst_rsp_valid", 16'(rsp_valid_w[k]), 16'd0);
      chk("rst_alu_opcode", 16'(alu_opcode_w[k]), 16'd0);
      chk("rst_rsp_x", 16'(rsp_x_w[k]), 16'd0);
    end

    for (int i = 0; i < 9; i++) begin
      issue(0, vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], vec[i][5], vec[i][6], 1'b1);
      chk("busy_after_accept", 16'(busy_w[0]), 16'd1);
    end
    wait_drain();

    // Latency with SETTLE_CYC=3: {y,x}=8'hE1.
    issue(1, 4'hC, 4'hF, 4'hF, 4'h1, 4'hE, 4'h1, 4'hE, 1'b1);
    wait_drain();

    // Back-pressure while a new command is pending.
    rsp_ready = 1'b0;
    issue(0, 4'h5, 4'h1, 4'h2, 4'hC, 4'h3, 4'hC, 4'h0, 1'b1);
    n = 0;
    while (!rsp_valid_w[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid_rise", 16'(rsp_valid_w[0]), 16'd1);
    @(posedge clk); #1;
    cmd_valid[0] = 1'b1; cmd_op = 4'h9; cmd_a = 4'h4; cmd_b = 4'h6;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("bp_alu_opcode_kept", 16'(alu_opcode_w[0]), 16'h5);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_busy", 16'(busy_w[0]), 16'd0);
    chk("bp_idle_cmd_ready", 16'(cmd_ready_w[0]), 16'd1);
    chk("bp_not_accepted_in_resp", 16'(alu_opcode_w[0]), 16'h5);
    alu_x = 4'h7; alu_y = 4'h7;
    e.op = 4'h9; e.x = 4'h1; e.y = 4'h0; e.lat = 8'd2;
    q0.push_back(e);
    @(posedge clk); #1;
    acc_cyc[0] = cyc;
    cmd_valid[0] = 1'b0;
    chk("bp_next_accept_op", 16'(alu_opcode_w[0]), 16'h9);
    chk("bp_next_accept_a", 16'(alu_a_w[0]), 16'h4);
    chk("bp_next_accept_b", 16'(alu_b_w[0]), 16'h6);
    chk("bp_next_busy", 16'(busy_w[0]), 16'd1);
    wait_drain();

    // Reset during WAIT discards the transaction.
    issue(0, 4'hE, 4'h1, 4'h1, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0);
    chk("midrst_in_wait", 16'(busy_w[0]), 16'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_rsp_valid", 16'(rsp_valid_w[0]), 16'd0);
    chk("midrst_busy", 16'(busy_w[0]), 16'd0);
    chk("midrst_cmd_ready", 16'(cmd_ready_w[0]), 16'd1);
    chk("midrst_alu_opcode", 16'(alu_opcode_w[0]), 16'd0);
    chk("midrst_alu_a", 16'(alu_a_w[0]), 16'd0);
    chk("midrst_alu_b", 16'(alu_b_w[0]), 16'd0);
    chk("midrst_rsp_op", 16'(rsp_op_w[0]), 16'd0);
    chk("midrst_rsp_x", 16'(rsp_x_w[0]), 16'd0);
    chk("midrst_rsp_y", 16'(rsp_y_w[0]), 16'd0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("midrst_no_rsp", 16'(rsp_valid_w[0]), 16'd0);

`ifdef ALU_ISSUER_OPCNT_EN
    // Preload the counter near its wrap point, then complete three transactions.
    force u_s1.op_count_q = 16'hFFFE;
    repeat (2) @(posedge clk);
    #1 release u_s1.op_count_q;
    chk("opcnt_preload", op_count_w[0], 16'hFFFE);
    issue(0, 4'h4, 4'h1, 4'h1, 4'h5, 4'h5, 4'h5, 4'h0, 1'b1);
    wait_drain();
    chk("opcnt_1", op_count_w[0], 16'hFFFF);
    issue(0, 4'h4, 4'h1, 4'h1, 4'h5, 4'h5, 4'h5, 4'h0, 1'b1);
    wait_drain();
    chk("opcnt_2", op_count_w[0], 16'h0000);
    issue(0, 4'h4, 4'h1, 4'h1, 4'h5, 4'h5, 4'h5, 4'h0, 1'b1);
    wait_drain();
    chk("opcnt_3", op_count_w[0], 16'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
